// File: rtl/countdown_pkg.sv
// State encodings shared by the countdown unit and anything that decodes its state.
package countdown_pkg;
    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/countdown_unit.sv
// Loadable down-counter with a one-cycle done pulse at zero and a sticky underflow flag.
// Load reaches RUN one cycle after acceptance. load_ready is high only in IDLE, so RUN and DONE stall new loads.
module countdown_unit
    import countdown_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int INIT  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             underflow
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             underflow_q, underflow_d;
    logic             initstate_q = 1'b1;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        case (state_q)
            IDLE: begin
                // A load wins over a simultaneous decrement.
                if (load_valid) begin
                    count_d = load_value;
                    state_d = (load_value != '0) ? RUN : DONE;
                end else if (dec) begin
                    if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // count is nonzero throughout RUN, so this cannot wrap.
                if (dec) begin
                    count_d = count_q - WIDTH'(1);
                    if (count_q == WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= WIDTH'(INIT);
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        initstate_q <= 1'b0;
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign zero       = (count_q == '0);
    assign count      = count_q;
    assign underflow  = underflow_q;

    always @* begin
        if (!initstate_q) begin
            assert (state_q != state_t'(2'b11));
            assert (load_ready == (state_q == IDLE));
            assert (!busy || (count_q != '0));
            assert ({1'b0, count_q} < {1'b1, {WIDTH{1'b0}}});
            assert (!done || (count_q == '0));
        end
    end

endmodule
